dmem_arbiter: RTL

- Shares the single core data-memory port (the cpu_ahb_mem side) between two requesters: master 0 is the pipeline MEM stage, master 1 is the debug/DMA port.
- Latches one transaction at a time and drives it onto the bus until the bus returns ready.
- Returns read data and a one-cycle ready/err pulse to the owner, and raises a pipeline stall while the MEM stage waits.
- Arbitration between masters is round-robin. A watchdog timeout and an alignment checker stop a bad access from hanging the core.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_align_chk.sv | 20 ++
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, MEM-stage size
// codes, the default watchdog limit and the latched request record.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_TIMEOUT = 255;

  localparam logic [2:0] SEL_BYTE = 3'b000;
  localparam logic [2:0] SEL_HALF = 3'b001;
  localparam logic [2:0] SEL_WORD = 3'b010;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_BUSY = 2'd1,
    STATE_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [2:0]  sel;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_align_chk.sv
// Flags an access whose size does not match its address alignment; also
// usable by the MEM stage to raise a misaligned-access trap.
module dmem_align_chk
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] sel,
  output logic       misaligned
);

  always_comb begin
    case (sel)
      SEL_BYTE: misaligned = 1'b0;
      SEL_HALF: misaligned = addr_lo[0];
      SEL_WORD: misaligned = |addr_lo;
      default:  misaligned = 1'b1;  // reserved size codes are never legal
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the core data-memory port between the MEM stage
// (master 0) and the debug/DMA port (master 1), with watchdog and alignment check.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DMEM_TIMEOUT,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [2:0]  m0_sel_i,
  input  logic [31:0] m0_wdata_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ready_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [2:0]  m1_sel_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ready_o,
  output logic        m1_err_o,
  output logic        stall_o,
  output logic        bus_ce_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [2:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i
);

  state_t           state;
  mem_req_t         lat, cand;
  logic             owner, last_owner;
  logic [CNT_W-1:0] cnt;

  logic elig0, elig1, grant_any, grant_m1, misaligned, timed_out;
  logic fin, fin_err, fin_m1;
  logic [31:0] fin_data;

  // A master is not re-granted while its completion pulse is still visible.
  assign elig0     = m0_req_i & ~m0_ready_o;
  assign elig1     = m1_req_i & ~m1_ready_o;
  assign grant_any = elig0 | elig1;
  assign grant_m1  = (elig0 & elig1) ? ~last_owner : elig1;

  assign cand = grant_m1 ? '{addr: m1_addr_i, we: m1_we_i, sel: m1_sel_i, wdata: m1_wdata_i}
                         : '{addr: m0_addr_i, we: m0_we_i, sel: m0_sel_i, wdata: m0_wdata_i};

  dmem_align_chk u_align_chk (
    .addr_lo    (cand.addr[1:0]),
    .sel        (cand.sel),
    .misaligned (misaligned)
  );

  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  // Completion decode shared by the misaligned, bus-ready and watchdog paths.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fin      = 1'b0;
    fin_err  = 1'b0;
    fin_data = '0;
    case (state)
      STATE_IDLE: begin
        if (grant_any && misaligned) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      STATE_BUSY: begin
        if (bus_ready_i) begin
          fin      = 1'b1;
          fin_data = lat.we ? 32'd0 : bus_rdata_i;
        end else if (timed_out) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign fin_m1 = (state == STATE_IDLE) ? grant_m1 : owner;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= STATE_IDLE;
      lat        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      bus_ce_o   <= 1'b0;
      m0_ready_o <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ready_o <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
    end else begin
      m0_ready_o <= 1'b0;
      m0_err_o   <= 1'b0;
      m1_ready_o <= 1'b0;
      m1_err_o   <= 1'b0;

      if (fin) begin
        if (fin_m1) begin
          m1_ready_o <= 1'b1;
          m1_err_o   <= fin_err;
          m1_rdata_o <= fin_data;
        end else begin
          m0_ready_o <= 1'b1;
          m0_err_o   <= fin_err;
          m0_rdata_o <= fin_data;
        end
      end

      case (state)
        STATE_IDLE: begin
          if (grant_any) begin
            lat        <= cand;
            owner      <= grant_m1;
            last_owner <= grant_m1;
            cnt        <= '0;
            if (misaligned) begin
              state <= STATE_RESP;
            end else begin
              state    <= STATE_BUSY;
              bus_ce_o <= 1'b1;
            end
          end
        end
        STATE_BUSY: begin
          cnt <= cnt + 1'b1;
          if (fin) begin
            state    <= STATE_RESP;
            bus_ce_o <= 1'b0;
          end
        end
        STATE_RESP: begin
          state <= STATE_IDLE;
          cnt   <= '0;
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign bus_we_o    = lat.we;
  assign bus_addr_o  = lat.addr;
  assign bus_sel_o   = lat.sel;
  assign bus_wdata_o = lat.wdata;

  assign stall_o = m0_req_i & ~m0_ready_o;

endmodule
